// File: rtl/sram_like_arbiter_if.sv
// SRAM-like command/response bundle shared by both requesters and the memory side.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Handshake: a command transfers on a cycle with req & addr_ok. Every transferred
  // command later receives exactly one data_ok, in acceptance order, with rdata valid then.
  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-requester (instruction/data) arbiter onto one SRAM-like port; data has priority,
// the grant locks while a command waits for addr_ok, and an owner FIFO routes data_ok.
module sram_like_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_like_arbiter_if.slave      inst_sram,
  sram_like_arbiter_if.slave      data_sram,
  sram_like_arbiter_if.master     sram,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic [1:0]              lock_state
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK_I   = 2'd1,
    LOCK_D   = 2'd2
  } lock_e;

  lock_e            lock_q, lock_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] owner_q, owner_d;   // one bit per slot, 1 = data requester

  logic sel_data;
  logic sel_any;
  logic gnt_req;
  logic full;
  logic accept;
  logic pop;
  logic head_owner;

  // A locked grant ignores the other requester until its command is accepted or withdrawn.
  always_comb begin
    sel_data = 1'b0;
    sel_any  = 1'b0;
    case (lock_q)
      LOCK_I: begin
        sel_data = 1'b0;
        sel_any  = 1'b1;
      end
      LOCK_D: begin
        sel_data = 1'b1;
        sel_any  = 1'b1;
      end
      default: begin
        sel_data = data_sram.req;
        sel_any  = data_sram.req | inst_sram.req;
      end
    endcase
  end

  assign gnt_req = sel_any & (sel_data ? data_sram.req : inst_sram.req);
  assign full    = (count_q == (PW+1)'(DEPTH));

  assign sram.req   = gnt_req & ~full;
  assign sram.wr    = sel_data ? data_sram.wr    : inst_sram.wr;
  assign sram.size  = sel_data ? data_sram.size  : inst_sram.size;
  assign sram.wstrb = sel_data ? data_sram.wstrb : inst_sram.wstrb;
  assign sram.addr  = sel_data ? data_sram.addr  : inst_sram.addr;
  assign sram.wdata = sel_data ? data_sram.wdata : inst_sram.wdata;

  assign accept = sram.req & sram.addr_ok;
  assign inst_sram.addr_ok = accept & ~sel_data;
  assign data_sram.addr_ok = accept &  sel_data;

  // A stray data_ok with nothing in flight is dropped.
  assign pop        = sram.data_ok & (count_q != '0);
  assign head_owner = owner_q[rptr_q];

  assign inst_sram.data_ok = pop & ~head_owner;
  assign data_sram.data_ok = pop &  head_owner;
  assign inst_sram.rdata   = sram.rdata;
  assign data_sram.rdata   = sram.rdata;

  assign outstanding = count_q;
  assign lock_state  = lock_q;

  always_comb begin
    lock_d  = lock_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    owner_d = owner_q;

    // Full with the owner still requesting leaves the lock untouched.
    if (accept) begin
      lock_d = UNLOCKED;
    end else if (sram.req) begin
      lock_d = sel_data ? LOCK_D : LOCK_I;
    end else if (!gnt_req) begin
      lock_d = UNLOCKED;
    end

    if (accept) begin
      owner_d[wptr_q] = sel_data;
      wptr_d          = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q  <= UNLOCKED;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_sram_like_arbiter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] outstanding;
  logic [1:0] lock_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sram_like_arbiter_if inst_if();
  sram_like_arbiter_if data_if();
  sram_like_arbiter_if mem_if();

  sram_like_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_sram   (inst_if),
    .data_sram   (data_if),
    .sram        (mem_if),
    .outstanding (outstanding),
    .lock_state  (lock_state)
  );

  always #5 clk = ~clk;

  // Reference model: owners of in-flight transactions oldest first (1 = data), and the
  // requester whose command is waiting for addr_ok (-1 none, 0 inst, 1 data).
  bit          exp_q[$];
  int          lock_owner = -1;
  int          e_gnt;
  logic        e_greq, e_req, e_i_aok, e_d_aok, e_i_dok, e_d_dok;
  logic [70:0] e_cmd;
  logic [2:0]  e_out;

  function automatic void model_eval();
    if (lock_owner >= 0)  e_gnt = lock_owner;
    else if (data_if.req) e_gnt = 1;
    else if (inst_if.req) e_gnt = 0;
    else                  e_gnt = -1;
    e_greq = (e_gnt == 1) ? data_if.req : ((e_gnt == 0) ? inst_if.req : 1'b0);
    e_req  = e_greq && (exp_q.size() < DEPTH);
    if (e_gnt == 1)
      e_cmd = {data_if.wr, data_if.size, data_if.wstrb, data_if.addr, data_if.wdata};
    else
      e_cmd = {inst_if.wr, inst_if.size, inst_if.wstrb, inst_if.addr, inst_if.wdata};
    e_i_aok = e_req && mem_if.addr_ok && (e_gnt == 0);
    e_d_aok = e_req && mem_if.addr_ok && (e_gnt == 1);
    e_i_dok = 1'b0;
    e_d_dok = 1'b0;
    if (mem_if.data_ok && exp_q.size() > 0) begin
      e_i_dok = (exp_q[0] == 1'b0);
      e_d_dok = (exp_q[0] == 1'b1);
    end
    e_out = 3'(exp_q.size());
  endfunction

  function automatic void model_commit();
    bit do_pop;
    model_eval();
    do_pop = mem_if.data_ok && (exp_q.size() > 0);
    if (do_pop) void'(exp_q.pop_front());
    if (e_req && mem_if.addr_ok) begin
      exp_q.push_back(e_gnt == 1);
      lock_owner = -1;
    end else if (e_req) begin
      lock_owner = e_gnt;
    end else if (lock_owner >= 0 && !e_greq) begin
      lock_owner = -1;
    end
  endfunction

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    inst_if.req = req; inst_if.wr = wr; inst_if.size = 2'd2; inst_if.wstrb = 4'hf;
    inst_if.addr = addr; inst_if.wdata = wdata;
  endtask

  task automatic drive_data(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    data_if.req = req; data_if.wr = wr; data_if.size = 2'd2; data_if.wstrb = 4'hf;
    data_if.addr = addr; data_if.wdata = wdata;
  endtask

  task automatic drive_mem(input logic aok, input logic dok, input logic [31:0] rdata);
    mem_if.addr_ok = aok; mem_if.data_ok = dok; mem_if.rdata = rdata;
  endtask

  task automatic idle();
    drive_inst(1'b0, 1'b0, 32'h0, 32'h0);
    drive_data(1'b0, 1'b0, 32'h0, 32'h0);
    drive_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (outstanding !== 3'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    else pass_cnt++;
    total_cnt++;
    if (lock_state !== 2'd0) $display("FAIL reset_lock: got %0d want 0", lock_state);
    else pass_cnt++;
    total_cnt++;
    if ({mem_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 5'b0)
      $display("FAIL reset_handshakes: got %b want 00000",
               {mem_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    exp_q.delete();
    lock_owner = -1;
  endtask

  task automatic test_priority();
    drive_inst(1'b1, 1'b0, 32'h1000, 32'h0);
    drive_data(1'b1, 1'b1, 32'h2000, 32'hdead_beef);
    drive_mem(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    total_cnt++;
    if (mem_if.addr !== 32'h2000 || mem_if.wr !== 1'b1)
      $display("FAIL prio_data_first: addr %h wr %b want 00002000 1", mem_if.addr, mem_if.wr);
    else pass_cnt++;
    total_cnt++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01)
      $display("FAIL prio_data_aok: got %b want 01", {inst_if.addr_ok, data_if.addr_ok});
    else pass_cnt++;
    next_cycle();
    data_if.req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (mem_if.addr !== 32'h1000 || {inst_if.addr_ok, data_if.addr_ok} !== 2'b10)
      $display("FAIL prio_inst_next: addr %h aok %b want 00001000 10", mem_if.addr,
               {inst_if.addr_ok, data_if.addr_ok});
    else pass_cnt++;
    next_cycle();
    idle();
    drive_mem(1'b0, 1'b1, 32'h11);
    @(negedge clk);
    total_cnt++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b01 || data_if.rdata !== 32'h11)
      $display("FAIL prio_drain1: dok %b rdata %h want 01 00000011",
               {inst_if.data_ok, data_if.data_ok}, data_if.rdata);
    else pass_cnt++;
    next_cycle();
    mem_if.rdata = 32'h22;
    @(negedge clk);
    total_cnt++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b10 || inst_if.rdata !== 32'h22)
      $display("FAIL prio_drain2: dok %b rdata %h want 10 00000022",
               {inst_if.data_ok, data_if.data_ok}, inst_if.rdata);
    else pass_cnt++;
    next_cycle();
    idle();
  endtask

  task automatic test_lock();
    drive_inst(1'b1, 1'b0, 32'h1000, 32'h0);
    drive_mem(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive_data(1'b1, 1'b0, 32'h2000, 32'h0);
      @(negedge clk);
      total_cnt++;
      if (mem_if.req !== 1'b1 || mem_if.addr !== 32'h1000 || data_if.addr_ok !== 1'b0)
        $display("FAIL lock_hold c%0d: req %b addr %h d_aok %b want 1 00001000 0", c,
                 mem_if.req, mem_if.addr, data_if.addr_ok);
      else pass_cnt++;
      next_cycle();
    end
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (inst_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h1000)
      $display("FAIL lock_accept: i_aok %b addr %h want 1 00001000", inst_if.addr_ok, mem_if.addr);
    else pass_cnt++;
    next_cycle();
    inst_if.req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (data_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h2000)
      $display("FAIL lock_then_data: d_aok %b addr %h want 1 00002000", data_if.addr_ok, mem_if.addr);
    else pass_cnt++;
    next_cycle();
    idle();
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b10)
      $display("FAIL lock_resp_order: got %b want 10", {inst_if.data_ok, data_if.data_ok});
    else pass_cnt++;
    next_cycle();
    next_cycle();
    idle();
  endtask

  task automatic test_full();
    drive_mem(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive_inst(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
      @(negedge clk);
      total_cnt++;
      if (inst_if.addr_ok !== 1'b1) $display("FAIL full_fill%0d: i_aok %b want 1", i, inst_if.addr_ok);
      else pass_cnt++;
      next_cycle();
    end
    @(negedge clk);
    total_cnt++;
    if (outstanding !== 3'd4 || mem_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0)
      $display("FAIL full_block: out %0d req %b i_aok %b want 4 0 0", outstanding, mem_if.req,
               inst_if.addr_ok);
    else pass_cnt++;
    next_cycle();
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (inst_if.data_ok !== 1'b1 || inst_if.addr_ok !== 1'b0)
      $display("FAIL full_pop_no_push: i_dok %b i_aok %b want 1 0", inst_if.data_ok, inst_if.addr_ok);
    else pass_cnt++;
    next_cycle();
    mem_if.data_ok = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (outstanding !== 3'd3 || inst_if.addr_ok !== 1'b1)
      $display("FAIL full_after_pop: out %0d i_aok %b want 3 1", outstanding, inst_if.addr_ok);
    else pass_cnt++;
    next_cycle();
    idle();
    mem_if.data_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) next_cycle();
    idle();
    @(negedge clk);
    total_cnt++;
    if (outstanding !== 3'd0) $display("FAIL full_drained: out %0d want 0", outstanding);
    else pass_cnt++;
  endtask

  task automatic test_order();
    logic [1:0]  want_dok[3];
    logic [31:0] got_rd;
    want_dok[0] = 2'b10; want_dok[1] = 2'b01; want_dok[2] = 2'b10;
    mem_if.addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_inst(i != 1, 1'b0, 32'h300 + 32'(i), 32'h0);
      drive_data(i == 1, 1'b0, 32'h400 + 32'(i), 32'h0);
      next_cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      drive_mem(1'b0, 1'b1, 32'hA + 32'(i));
      @(negedge clk);
      got_rd = want_dok[i][1] ? inst_if.rdata : data_if.rdata;
      total_cnt++;
      if ({inst_if.data_ok, data_if.data_ok} !== want_dok[i] || got_rd !== 32'hA + 32'(i))
        $display("FAIL order_resp%0d: dok %b rdata %h want %b %h", i,
                 {inst_if.data_ok, data_if.data_ok}, got_rd, want_dok[i], 32'hA + 32'(i));
      else pass_cnt++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_empty_data_ok();
    idle();
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00)
      $display("FAIL empty_dok: got %b want 00", {inst_if.data_ok, data_if.data_ok});
    else pass_cnt++;
    next_cycle();
    idle();
    @(negedge clk);
    total_cnt++;
    if (outstanding !== 3'd0) $display("FAIL empty_count: out %0d want 0", outstanding);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive_inst(1'b1, 1'b0, 32'h500, 32'h0);
    mem_if.addr_ok = 1'b1;
    next_cycle();
    next_cycle();
    inst_if.req = 1'b0;
    drive_data(1'b1, 1'b1, 32'h600, 32'h5);
    mem_if.addr_ok = 1'b0;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (outstanding !== 3'd2 || lock_state === 2'd0)
      $display("FAIL rstmid_setup: out %0d lock %0d want 2 locked", outstanding, lock_state);
    else pass_cnt++;
    #1;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (outstanding !== 3'd0 || lock_state !== 2'd0)
      $display("FAIL rstmid_clear: out %0d lock %0d want 0 0", outstanding, lock_state);
    else pass_cnt++;
    exp_q.delete();
    lock_owner = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00 || outstanding !== 3'd0)
      $display("FAIL rstmid_ignore: dok %b out %0d want 00 0",
               {inst_if.data_ok, data_if.data_ok}, outstanding);
    else pass_cnt++;
    next_cycle();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      inst_if.req   = ($urandom_range(0, 99) < 55);
      inst_if.wr    = 1'($urandom);
      inst_if.size  = 2'($urandom);
      inst_if.wstrb = 4'($urandom);
      inst_if.addr  = $urandom;
      inst_if.wdata = $urandom;
      data_if.req   = ($urandom_range(0, 99) < 45);
      data_if.wr    = 1'($urandom);
      data_if.size  = 2'($urandom);
      data_if.wstrb = 4'($urandom);
      data_if.addr  = $urandom;
      data_if.wdata = $urandom;
      mem_if.addr_ok = ($urandom_range(0, 99) < 50);
      mem_if.data_ok = ($urandom_range(0, 99) < 40);
      mem_if.rdata   = $urandom;
      @(negedge clk);
      model_eval();
      total_cnt++;
      if ({mem_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !==
          {e_req, e_i_aok, e_d_aok, e_i_dok, e_d_dok})
        $display("FAIL rand_hs c%0d: got %b want %b", c,
                 {mem_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok},
                 {e_req, e_i_aok, e_d_aok, e_i_dok, e_d_dok});
      else pass_cnt++;
      total_cnt++;
      if ({mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata} !== e_cmd)
        $display("FAIL rand_cmd c%0d: got %h want %h", c,
                 {mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata}, e_cmd);
      else pass_cnt++;
      total_cnt++;
      if (outstanding !== e_out) $display("FAIL rand_out c%0d: got %0d want %0d", c, outstanding, e_out);
      else pass_cnt++;
      if (c % 16 == 0) begin
        total_cnt++;
        if (inst_if.rdata !== mem_if.rdata || data_if.rdata !== mem_if.rdata)
          $display("FAIL rand_rdata c%0d: got %h/%h want %h", c, inst_if.rdata, data_if.rdata,
                   mem_if.rdata);
        else pass_cnt++;
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_full();
    test_order();
    test_empty_data_ok();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter DEPTH, 4, max outstanding (address-accepted, data-not-returned) transactions; power of two, >= 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  instruction requester command.
REQ-005 inst_sram_addr_ok/data_ok  out  1/1  instruction requester handshakes.
REQ-006 inst_sram_rdata  out  32  read data to instruction requester.
REQ-007 data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data requester command.
REQ-008 data_sram_addr_ok/data_ok  out  1/1  data requester handshakes.
REQ-009 data_sram_rdata  out  32  read data to data requester.
REQ-010 sram_req/wr/size/wstrb/addr/wdata  out  1/1/2/4/32/32  shared memory-side command.
REQ-011 sram_addr_ok/data_ok  in  1/1  memory-side handshakes; responses return in acceptance order.
REQ-012 sram_rdata  in  32  memory-side read data.
REQ-013 outstanding  out  log2(DEPTH)+1  current count of in-flight transactions.

Function
REQ-014 Grant selection, unlocked: data requester wins if data_sram_req=1, else instruction requester if inst_sram_req=1, else none.
REQ-015 Lock FSM states UNLOCKED, LOCK_I, LOCK_D; enter LOCK_x when sram_req=1 and sram_addr_ok=0 with x granted; return to UNLOCKED on the cycle sram_req & sram_addr_ok.
REQ-016 While locked, grant stays on the locked requester regardless of the other's req; memory-side command fields stay stable until accepted.
REQ-017 full = (outstanding == DEPTH), from registered state only.
REQ-018 sram_req = granted requester's req & !full; sram_wr/size/wstrb/addr/wdata mux from granted requester (inst when none granted).
REQ-019 Granted requester's addr_ok = sram_req & sram_addr_ok, combinational; non-granted addr_ok = 0.
REQ-020 Accept (sram_req & sram_addr_ok) pushes owner id (0 inst, 1 data) into a DEPTH-entry FIFO; write pointer wraps modulo DEPTH.
REQ-021 sram_data_ok with FIFO non-empty pops head; owner's data_ok = 1 same cycle (combinational), other's data_ok = 0; read pointer wraps modulo DEPTH.
REQ-022 inst_sram_rdata and data_sram_rdata both equal sram_rdata every cycle; writes also receive data_ok.
REQ-023 sram_data_ok with FIFO empty: ignored, no data_ok to either requester, count unchanged.
REQ-024 Push and pop same cycle: count unchanged, both pointers advance; pop does not free a slot for a push in the same cycle when full.
REQ-025 Lock may hold with full=1; sram_req deasserts until a pop, lock unchanged.
REQ-026 Requester dropping req while locked (flush): block keeps presenting latched grant owner's current inputs; no invented transaction if req=0, lock clears when granted req=0.

Reset
REQ-027 Reset asserted: outstanding=0, pointers=0, lock=UNLOCKED, all FIFO entries don't-care; all addr_ok/data_ok outputs 0 and sram_req 0 while requesters idle.
REQ-028 Reset mid-operation discards in-flight ownership; any later sram_data_ok is ignored per REQ-023.

Verification
REQ-029 Both reqs=1, addr 0x1000 inst / 0x2000 data, sram_addr_ok=1 -> sram_addr=0x2000, data_sram_addr_ok=1, inst next cycle at 0x1000.
REQ-030 Inst req, sram_addr_ok=0 for 3 cycles, data req rises in cycle 2 -> sram_addr stays inst address until accepted, then data granted.
REQ-031 Push 4 reads (DEPTH=4) without data_ok -> outstanding=4, sram_req=0, fifth requester sees addr_ok=0; one sram_data_ok -> outstanding=3, next cycle push allowed.
REQ-032 Accept order I,D,I then three data_ok with rdata 0xA,0xB,0xC -> inst data_ok with 0xA, data data_ok with 0xB, inst data_ok with 0xC.
REQ-033 sram_data_ok pulse with outstanding=0 -> no data_ok output, outstanding stays 0.
REQ-034 Assert reset with outstanding=2 and LOCK_D -> outstanding=0, UNLOCKED immediately, next data_ok ignored.
